mc_main_control: RTL and testbench

Multi-cycle main control FSM for the MIPS datapath. Decodes the 6-bit opcode and sequences fetch, decode, execute, memory and write-back steps. It drives the datapath muxes and write enables, and produces the 2-bit `ALUOp` consumed by the ALU control stage. Memory steps stall on a `mem_ready` handshake from the unified instruction/data memory.

---
 rtl/mc_main_control.sv | 187 ++++++++++++++++++
 tb/tb_mc_main_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// mc_main_control -- multi-cycle main control FSM for the MIPS datapath.
//
// Decodes the 6-bit opcode and sequences fetch, decode, execute, memory and
// write-back steps. Memory steps (FETCH, MEM_READ, MEM_WRITE) stall until
// mem_ready is seen high.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   Op[5:0]        in   opcode (IR[31:26])
//   mem_ready      in   memory completes the current access this cycle
//   PCWrite, PCWriteCond, PCWriteCondNE          out  PC write controls
//   IorD, MemRead, MemWrite, IRWrite             out  memory controls
//   MemtoReg, RegWrite, RegDst                   out  register file controls
//   ALUSrcA        out  ALU A select
//   ALUSrcB[1:0]   out  ALU B select
//   ALUOp[1:0]     out  00 add, 01 sub, 10 use funct
//   PCSource[1:0]  out  00 ALU, 01 ALUOut, 10 jump target
//   state[3:0]     out  current state (debug)
//   illegal_op     out  one-cycle pulse in DECODE on an unsupported opcode
//
// Optional feature: define MC_CONTROL_BNE_EN to decode opcode 000101 as BNE
// (state 12, PCWriteCondNE). Without it, 000101 is illegal and state 12 is an
// unused code.
module mc_main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_BNE       = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Debug view reads 0 while reset is held, even before the first edge.
  assign state = reset ? 4'd0 : state_q;

  always_comb begin
    state_d       = S_FETCH;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    illegal_op    = 1'b0;

    // Outputs stay at their zero defaults while reset is high so no write
    // enable can fire in the cycle that aborts an instruction.
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (Op)
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_RTYPE:     state_d = S_R_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_ADDI_EXEC;
`ifdef MC_CONTROL_BNE_EN
            OP_BNE:       state_d = S_BNE;
`endif
            default: begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          state_d  = mem_ready ? S_FETCH : S_MEM_WRITE;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = S_R_WB;
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
`ifdef MC_CONTROL_BNE_EN
        S_BNE: begin
          ALUSrcA       = 1'b1;
          ALUOp         = 2'b01;
          PCWriteCondNE = 1'b1;
          PCSource      = 2'b01;
        end
`endif
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          RegWrite = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control. The driver walks each instruction
// through its step list, pushing the expected control vector for every cycle;
// a negedge monitor pops and compares against the DUT outputs.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op)
  );

  // {PCWrite,PCWriteCond,PCWriteCondNE,IorD,MemRead,MemWrite,IRWrite,
  //  MemtoReg,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,state,illegal_op}
  logic [21:0] got;
  assign got = {PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
                IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, state, illegal_op};

  typedef struct {
    logic [21:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Expected control word for a cycle spent in step st.
  function automatic logic [21:0] mk(input int st, input bit mr, input bit ill);
    bit pcw = 0, pcwc = 0, pcwne = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    bit m2r = 0, rw = 0, rd = 0, asa = 0;
    bit [1:0] asb = 0, aop = 0, pcs = 0;
    bit [3:0] s4 = st[3:0];
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      12: begin asa = 1; aop = 2'b01; pcwne = 1; pcs = 2'b01; end
      default: ;
    endcase
    return {pcw, pcwc, pcwne, iord, mrd, mwr, irw, m2r, rw, rd, asa,
            asb, aop, pcs, s4, ill};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h exp=%h (t=%0t)", e.tag, got, e.v, $time);
      end
    end
  end

  task automatic cyc(input bit rst, input bit mr, input logic [5:0] op,
                     input logic [21:0] e, input string tag);
    exp_t x;
    reset = rst;
    mem_ready = mr;
    Op = op;
    x.v = e;
    x.tag = tag;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // One memory-access step: ns stall cycles then the completing cycle.
  task automatic mem_step(input int st, input int ns, input logic [5:0] op,
                          input string tag);
    repeat (ns) cyc(0, 0, op, mk(st, 0, 0), {tag, "_stall"});
    cyc(0, 1, op, mk(st, 1, 0), tag);
  endtask

  // Expected step list for each opcode, taken from the instruction's
  // documented sequence; an empty list marks an illegal opcode.
  function automatic void steps_for(input logic [5:0] op, output int s[$]);
    s = {};
    case (op)
      6'b100011: s = {2, 3, 4};
      6'b101011: s = {2, 5};
      6'b000000: s = {6, 7};
      6'b001000: s = {10, 11};
      6'b000100: s = {8};
      6'b000010: s = {9};
`ifdef MC_CONTROL_BNE_EN
      6'b000101: s = {12};
`endif
      default: s = {};
    endcase
  endfunction

  task automatic run(input logic [5:0] op, input int fs, input int ms,
                     input bit abort, input string tag);
    int  s[$];
    bit  r;
    steps_for(op, s);
    mem_step(0, fs, 6'($urandom), {tag, "_fetch"});
    r = 1'($urandom);
    if (s.size() == 0) begin
      cyc(0, r, op, mk(1, r, 1), {tag, "_illegal"});
      return;
    end
    cyc(0, r, op, mk(1, r, 0), {tag, "_decode"});
    foreach (s[i]) begin
      if (s[i] == 3 || s[i] == 5) begin
        if (abort) begin
          r = 1'($urandom);
          cyc(1, r, op, '0, {tag, "_abort"});
          return;
        end
        mem_step(s[i], ms, op, $sformatf("%s_s%0d", tag, s[i]));
      end else begin
        r = 1'($urandom);
        cyc(0, r, op, mk(s[i], r, 0), $sformatf("%s_s%0d", tag, s[i]));
      end
    end
  endtask

  localparam logic [5:0] OPS [8] = '{6'b100011, 6'b101011, 6'b000000,
                                     6'b001000, 6'b000100, 6'b000010,
                                     6'b000101, 6'b111111};

  initial begin
    @(posedge clk);
    #1;
    cyc(1, 1, 6'd0, '0, "reset0");
    cyc(1, 1, 6'd0, '0, "reset1");
    run(6'b111111, 0, 0, 0, "ill");
    run(6'b100011, 0, 0, 0, "lw");
    run(6'b101011, 0, 3, 0, "sw_stall");
    run(6'b000000, 0, 0, 0, "rtype");
    run(6'b001000, 0, 0, 0, "addi");
    run(6'b000100, 0, 0, 0, "beq");
    run(6'b000010, 0, 0, 0, "j");
    run(6'b000101, 0, 0, 0, "bne");
    run(6'b100011, 2, 0, 1, "lw_abort");
    run(6'b100011, 1, 2, 0, "lw_stall");
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      int k;
      k = $urandom_range(0, 8);
      if (k == 8) op = 6'($urandom);
      else        op = OPS[k];
      run(op, $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 15) == 0), "rand");
    end
    cyc(1, 0, 6'd0, '0, "reset_end");
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
